i2s_tx: RTL and testbench
=========================

Name: i2s_tx

Overview:
- Downstream consumer of the dds block. Acts as the audio sample-rate master and emits a one-cycle query_sine strobe once per frame.
- Captures the returned sine sample after a fixed latency and serializes it as standard Philips I2S. The same sample goes to both left and right slots, driving the external DAC.
- With the defaults and a 24.576 MHz clk the frame rate is 48 kHz.

Parameters:
DATA_WDTH, 24, width of the two's-complement sample on sine.
SLOT_WDTH, 32, bclk periods per channel slot; must be >= DATA_WDTH.
SCLK_DIV, 4, clk cycles per bclk half-period; bclk period is 2*SCLK_DIV clk cycles.
QUERY_LAT, 3, clk cycles from the query_sine strobe to a valid sine; must be <= 2*SCLK_DIV-2.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst  input  1  synchronous reset, active-high.
query_sine  output  1  one-cycle strobe requesting the next sample from dds.
sine  input  DATA_WDTH  sample returned by dds, valid QUERY_LAT cycles after the strobe.
mute  input  1  sampled at frame start; when 1, the whole frame transmits zeros.
bclk  output  1  I2S bit clock.
lrclk  output  1  I2S word select; 0 = left slot, 1 = right slot.
sdata  output  1  I2S serial data, MSB first.

Behaviour:
- Reset values (while rst=1, registered):
  - bclk=0, lrclk=1, sdata=0, query_sine=0.
  - div_cnt=0, bit_cnt=2*SLOT_WDTH-1.
  - Hold register and shift register = 0; muted flag = 0.
- rst asserted mid-frame aborts the frame immediately; no partial words resume.
- Divider:
  - div_cnt counts 0..SCLK_DIV-1 and wraps.
  - On wrap, bclk toggles. A toggle from 1 to 0 is a "fall event", and all I2S outputs change only on fall events.
  - The first fall event after reset occurs at the end of clk cycle 2*SCLK_DIV-1.
- Bit counter:
  - On each fall event, bit_cnt increments modulo 2*SLOT_WDTH.
  - lrclk is updated to (new bit_cnt >= SLOT_WDTH).
  - Frame start is the fall event where bit_cnt becomes 0.
- query_sine:
  - Goes high for exactly one cycle: the cycle right after the frame-start fall event, i.e. the first cycle with lrclk=0.
  - Exactly one pulse per frame of 2*SLOT_WDTH*2*SCLK_DIV clk cycles.
- Capture:
  - If query_sine is high in cycle N, the hold register loads sine at the end of cycle N+QUERY_LAT.
  - mute is registered into the muted flag at the frame-start fall event.
- Serialization (one-bclk I2S delay):
  - At the fall event where bit_cnt becomes 1 or SLOT_WDTH+1, load the shift register with the hold register, or with zero if muted=1.
  - The load is left-justified in SLOT_WDTH bits, zero-padded in the LSBs.
  - sdata takes its MSB in that same event.
  - At every other fall event, sdata takes the next shift-register bit.
  - Bit at slot index k (k=1..SLOT_WDTH) is sample bit DATA_WDTH-k for k<=DATA_WDTH, otherwise 0.
  - The last pad bit continues into the next slot's bit index 0 (bit_cnt = 0 or SLOT_WDTH).
- Sample handling:
  - The sample is sent unmodified (two's complement).
  - Left and right slots carry the identical sample from the same frame's capture.
- sine is ignored in every cycle except the capture cycle.
- bclk, lrclk and sdata are glitch-free register outputs; lrclk and sdata never change except on fall events.

Test Plan:
- Reset release, run 3 frames with defaults → first fall event at clk cycle 7; query_sine pulses at cycles 8, 520, 1032; bclk period 8 cycles; lrclk low 256 / high 256 cycles.
- sine=24'hA5A5A5 valid from strobe+3 → sdata in left slot indices 1..24 = 101001011010010110100101, indices 25..32 and index 0 of the next slot = 0; the right slot is identical.
- sine=24'h800000 (most negative) → left slot index 1 = 1, indices 2..24 = 0; sine=24'h7FFFFF → index 1 = 0, indices 2..24 = 1.
- mute=1 held across one frame start, sine=24'hFFFFFF → the whole frame sdata=0; mute=0 before the next frame start → the next frame carries the sample.
- sine changes at strobe+2 and strobe+4 → only the value present at strobe+3 is transmitted.
- rst pulsed for 1 cycle mid-right-slot → outputs return to reset values the next cycle; the first fall event is 8 cycles after release; no query_sine is emitted before the new frame start.

Source files
------------

// File: rtl/i2s_tx.sv
// Philips I2S transmitter and audio sample-rate master: requests one sample per
// frame from the dds, captures it after a fixed latency and sends it in both slots.
module i2s_tx #(
  parameter int unsigned DATA_WDTH = 24,
  parameter int unsigned SLOT_WDTH = 32,
  parameter int unsigned SCLK_DIV  = 4,
  parameter int unsigned QUERY_LAT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 query_sine,
  input  logic [DATA_WDTH-1:0] sine,
  input  logic                 mute,
  output logic                 bclk,
  output logic                 lrclk,
  output logic                 sdata
);

  localparam int unsigned DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int unsigned BIT_W = $clog2(2 * SLOT_WDTH);
  localparam int unsigned LAT_W = $clog2(QUERY_LAT + 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_WDTH - 1);

  logic [DIV_W-1:0]     div_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [BIT_W-1:0]     bit_nxt;
  logic [LAT_W-1:0]     lat_cnt;
  logic [DATA_WDTH-1:0] hold;
  logic [SLOT_WDTH-1:0] shreg;
  logic [SLOT_WDTH-1:0] load_val;
  logic                 muted;
  logic                 div_wrap;
  logic                 fall;
  logic                 capture;
  logic                 load;

  always_comb begin
    div_wrap = (div_cnt == DIV_W'(SCLK_DIV - 1));
    fall     = div_wrap && bclk;
    bit_nxt  = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);
    // Slot index 1 of each slot is where the word is loaded (one-bclk I2S delay).
    load     = (bit_nxt == BIT_W'(1)) || (bit_nxt == BIT_W'(SLOT_WDTH + 1));
    capture  = (QUERY_LAT == 0) ? query_sine : (lat_cnt == LAT_W'(1));
    load_val = muted ? '0 : (SLOT_WDTH'(hold) << (SLOT_WDTH - DATA_WDTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt    <= '0;
      bclk       <= 1'b0;
      bit_cnt    <= BIT_LAST;
      lrclk      <= 1'b1;
      sdata      <= 1'b0;
      query_sine <= 1'b0;
      lat_cnt    <= '0;
      hold       <= '0;
      shreg      <= '0;
      muted      <= 1'b0;
    end else begin
      query_sine <= 1'b0;
      div_cnt    <= div_wrap ? '0 : div_cnt + DIV_W'(1);
      if (div_wrap) begin
        bclk <= ~bclk;
      end

      if (query_sine) begin
        lat_cnt <= LAT_W'(QUERY_LAT);
      end else if (lat_cnt != '0) begin
        lat_cnt <= lat_cnt - LAT_W'(1);
      end
      if (capture) begin
        hold <= sine;
      end

      if (fall) begin
        bit_cnt <= bit_nxt;
        lrclk   <= (bit_nxt >= BIT_W'(SLOT_WDTH));
        if (bit_nxt == '0) begin
          query_sine <= 1'b1;
          muted      <= mute;
        end
        if (load) begin
          sdata <= load_val[SLOT_WDTH-1];
          shreg <= load_val << 1;
        end else begin
          sdata <= shreg[SLOT_WDTH-1];
          shreg <= shreg << 1;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Scoreboard bench for i2s_tx: the driver answers each query_sine and queues the
// hand-computed slot word; the monitor rebuilds each frame from bclk falls and compares.
module tb_i2s_tx;

  localparam int NF = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        query_sine;
  logic [23:0] sine;
  logic        mute;
  logic        bclk;
  logic        lrclk;
  logic        sdata;

  int tests = 0;
  int fails = 0;
  int idx = 0;
  int frames_checked = 0;
  int glitch_err = 0;

  logic [31:0] exp_q[$];

  // frame 3 is muted, frame 5 has disturbed sine around the capture cycle,
  // frame 6 is aborted by a reset in its right slot.
  logic [23:0] sine_tab[NF] = '{24'hA5A5A5, 24'h800000, 24'h7FFFFF, 24'hFFFFFF,
                                24'hFFFFFF, 24'h123456, 24'h0F0F0F, 24'h5A5A5A};
  logic [31:0] word_tab[NF] = '{32'hA5A5A500, 32'h80000000, 32'h7FFFFF00, 32'h00000000,
                                32'hFFFFFF00, 32'h12345600, 32'h0F0F0F00, 32'h5A5A5A00};
  bit          mute_tab[NF] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  always #5 clk = ~clk;

  i2s_tx #(
    .DATA_WDTH(24),
    .SLOT_WDTH(32),
    .SCLK_DIV (4),
    .QUERY_LAT(3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .query_sine(query_sine),
    .sine      (sine),
    .mute      (mute),
    .bclk      (bclk),
    .lrclk     (lrclk),
    .sdata     (sdata)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_bclk"},  64'(bclk),       64'(0));
    check({tag, "_lrclk"}, 64'(lrclk),      64'(1));
    check({tag, "_sdata"}, 64'(sdata),      64'(0));
    check({tag, "_query"}, 64'(query_sine), 64'(0));
  endtask

  task automatic wait_frames(input int n, input int budget);
    for (int i = 0; i < budget && frames_checked < n; i++) @(negedge clk);
    if (frames_checked < n) begin
      tests++;
      fails++;
      $display("FAIL frame_timeout: got %0d frames expected %0d", frames_checked, n);
    end
  endtask

  // Driver: sine is only correct in the capture cycle (strobe+3), inverted elsewhere.
  initial begin
    sine = '0;
    mute = mute_tab[0];
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && query_sine === 1'b1 && idx < NF) begin
        exp_q.push_back(word_tab[idx]);
        for (int j = 1; j <= 5; j++) begin
          @(posedge clk);
          #1;
          sine = (j == 3) ? sine_tab[idx] : ~sine_tab[idx];
        end
        if (idx + 1 < NF) mute = mute_tab[idx + 1];
        idx++;
      end
    end
  end

  // Monitor: cycle 0 is the first cycle after the last reset edge.
  int          cyc, last_fall, last_lr_chg, qn, bidx;
  logic        prev_bclk, prev_lr, prev_sd, prev_q, seen_fall, have_chg, in_frame;
  logic [63:0] cap;
  logic [31:0] w;

  always @(negedge clk) begin
    if (rst !== 1'b0) begin
      cyc = -1; qn = 0; bidx = 0;
      prev_bclk = 1'b0; prev_lr = 1'b1; prev_sd = 1'b0; prev_q = 1'b0;
      seen_fall = 1'b0; have_chg = 1'b0; in_frame = 1'b0; cap = '0;
    end else begin
      cyc++;
      if (query_sine) begin
        check("query_cycle", 64'(cyc), 64'(8 + 512 * qn));
        qn++;
        if (prev_q) glitch_err++;
      end
      if (prev_bclk && !bclk) begin
        if (!seen_fall) check("first_fall", 64'(cyc), 64'(8));
        else if (cyc - last_fall != 8) glitch_err++;
        seen_fall = 1'b1;
        last_fall = cyc;
        if (lrclk != prev_lr) begin
          if (have_chg) check("lrclk_run", 64'(cyc - last_lr_chg), 64'(256));
          have_chg = 1'b1;
          last_lr_chg = cyc;
        end
        if (prev_lr && !lrclk) begin
          bidx = 0;
          in_frame = 1'b1;
        end else begin
          bidx++;
        end
        if (in_frame && bidx < 64) begin
          if (lrclk != (bidx >= 32)) glitch_err++;
          cap[63 - bidx] = sdata;
          if (bidx == 63) begin
            if (exp_q.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL frame_sdata: got %h expected <no queued word>", cap);
            end else begin
              w = exp_q.pop_front();
              check("frame_sdata", cap, {1'b0, w[31:1], w[0], w[31:1]});
            end
            frames_checked++;
          end
        end
      end else if (lrclk !== prev_lr || sdata !== prev_sd) begin
        glitch_err++;
      end
      prev_bclk = bclk;
      prev_lr   = lrclk;
      prev_sd   = sdata;
      prev_q    = query_sine;
    end
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("rst0");
    @(posedge clk);
    #1 rst = 1'b0;

    wait_frames(6, 4000);
    for (int i = 0; i < 1000 && idx < 7; i++) @(negedge clk);
    if (idx < 7) begin
      tests++;
      fails++;
      $display("FAIL strobe_timeout: got %0d strobes expected 7", idx);
    end

    repeat (300) @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_values("rst1");

    wait_frames(7, 1000);
    check("glitches", 64'(glitch_err), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
